ysyx_23060187_rf_scoreboard: RTL and testbench
==============================================

Name: ysyx_23060187_rf_scoreboard

Overview:
Parametrised general-purpose register file for the pipelined NPC core. It has NREAD combinational read ports and one write port with write-to-read bypass. x0 is hardwired to zero. Each register carries a pending-write scoreboard counter, so the issue stage can detect RAW hazards and stall. It sits between decode/issue (reads, allocation) and writeback (write), and exports one debug register for the simulation environment.

Parameters:
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 32, register data width
NREAD, 2, number of read ports (1..4)
CNT_WIDTH, 2, width of each pending-write counter; max outstanding writes per register = 2**CNT_WIDTH-1
DBG_IDX, 10, index of the register driven on dbg_gpr

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
wen  input  1  writeback write enable
waddr  input  ADDR_WIDTH  writeback destination index
wdata  input  DATA_WIDTH  writeback data
raddr  input  NREAD*ADDR_WIDTH  read indices; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rdata  output  NREAD*DATA_WIDTH  read data, packed the same way
rready  output  NREAD  per-port operand valid, i.e. no pending write remains after bypass
alloc_en  input  1  issue stage reserves destination alloc_addr
alloc_addr  input  ADDR_WIDTH  destination being reserved
alloc_ready  output  1  allocation can be accepted this cycle
flush  input  1  pipeline flush; clears all pending counters
dbg_gpr  output  DATA_WIDTH  current contents of register DBG_IDX

Behaviour:
- Reset (rst=1 at posedge):
  - all registers and all counters go to 0.
  - rst overrides wen, alloc_en and flush in that cycle.
  - After reset: rdata=0 and rready all 1 for any address; alloc_ready=1; dbg_gpr=0.
- Register 0:
  - writes are discarded.
  - reads always return 0 with rready=1.
  - alloc to 0 is accepted (alloc_ready=1) but has no effect.
- Write: wen=1, waddr!=0 → rf[waddr]<=wdata at the edge; visible on reads from the next cycle.
- Read (combinational, zero latency):
  - rdata_i = rf[raddr_i], except when wen=1 and waddr==raddr_i!=0; then rdata_i = wdata (same-cycle bypass).
- Counter cnt[r], per register r≠0:
  - alloc_en accepted → +1
  - wen with waddr==r → −1, saturating at 0; a write to a register with cnt 0 still updates data.
  - Accepted alloc and write to the same r in the same cycle → cnt unchanged.
- rready_i:
  - 1 if raddr_i==0 or cnt[raddr_i]==0;
  - else 1 if the bypass hits and cnt[raddr_i]==1;
  - else 0.
  - rdata is don't-care when rready_i=0.
- alloc_ready:
  - 0 only when alloc_addr!=0, cnt[alloc_addr]==max, and there is no same-cycle write to alloc_addr.
  - alloc_en with alloc_ready=0 is ignored; the issuer must hold it.
- flush=1 (rst=0):
  - all counters go to 0 at the edge, and an alloc in the same cycle is dropped.
  - A same-cycle write still updates register data.
- Multiple read ports with the same address return identical data and ready.
- dbg_gpr = rf[DBG_IDX], registered value with no bypass.
- No X on any output after the first reset.

Test Plan:
- Reset, then read all 32 indices on both ports → rdata=0, rready=11, alloc_ready=1.
- Write x5=0xDEADBEEF; same cycle raddr0=5 → rdata0=0xDEADBEEF via bypass. Next cycle, with wen=0 → still 0xDEADBEEF.
- wen=1, waddr=0, wdata=0x1234, then read x0 → 0, rready=1. alloc x0 ×5 → alloc_ready stays 1.
- Scoreboard sequence (CNT_WIDTH=2):
  - alloc x7 ×3 → cnt=3.
  - 4th alloc → alloc_ready=0 and it is ignored.
  - write x7=1 → rready for x7 stays 0.
  - two more writes x7 → the last is bypassed with rready=1, and x7 reads 3 afterwards.
- Simultaneous alloc x9 and write x9=0x55 with cnt=1 → cnt stays 1, rf[9]=0x55. Another write → cnt 0.
- alloc x3 ×2, then flush with same-cycle write x3=0xA and alloc x4 → all counters 0, x3=0xA, x4 ready. Asserting rst mid-sequence → everything 0 next cycle.

Source files
------------

// File: rtl/ysyx_23060187_rf_scoreboard.sv
// General-purpose register file with write-to-read bypass and per-register
// pending-write counters so the issue stage can detect RAW hazards and stall.
module ysyx_23060187_rf_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int CNT_WIDTH  = 2,
  parameter int DBG_IDX    = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wen,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
  output logic [NREAD*DATA_WIDTH-1:0] rdata,
  output logic [NREAD-1:0]            rready,
  input  logic                        alloc_en,
  input  logic [ADDR_WIDTH-1:0]       alloc_addr,
  output logic                        alloc_ready,
  input  logic                        flush,
  output logic [DATA_WIDTH-1:0]       dbg_gpr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] rf_q  [DEPTH];
  logic [CNT_WIDTH-1:0]  cnt_q [DEPTH];
  logic [CNT_WIDTH-1:0]  cnt_d [DEPTH];
  logic                  wr_hit;
  logic                  alloc_acc;

  assign wr_hit = wen && (waddr != '0);

  // A same-cycle write frees a slot, so a full counter can still take an alloc.
  assign alloc_ready = !((alloc_addr != '0) && (cnt_q[alloc_addr] == CNT_MAX) &&
                         !(wr_hit && (waddr == alloc_addr)));
  assign alloc_acc   = alloc_en && alloc_ready && (alloc_addr != '0) && !flush;

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (r != 0) begin
        if (alloc_acc && (alloc_addr == ADDR_WIDTH'(r))) begin
          if (!(wr_hit && (waddr == ADDR_WIDTH'(r)))) begin
            cnt_d[r] = cnt_q[r] + CNT_WIDTH'(1);
          end
        end else if (wr_hit && (waddr == ADDR_WIDTH'(r)) && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        rf_q[r]  <= '0;
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      if (wr_hit) begin
        rf_q[waddr] <= wdata;
      end
    end
  end

  // rf_q[0] is reset to zero and never written, so x0 reads need no special case.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  byp;
    assign ra  = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign byp = wr_hit && (waddr == ra);
    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = byp ? wdata : rf_q[ra];
    assign rready[i] = (ra == '0) || (cnt_q[ra] == '0) ||
                       (byp && (cnt_q[ra] == CNT_WIDTH'(1)));
  end

  assign dbg_gpr = rf_q[DBG_IDX];

endmodule

// File: tb/tb_ysyx_23060187_rf_scoreboard.sv
// Bench for the register-file scoreboard: directed scenarios plus random traffic
// checked every cycle against an array-based reference model.
module tb_ysyx_23060187_rf_scoreboard;

  logic        clk;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rready;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        alloc_ready;
  logic        flush;
  logic [31:0] dbg_gpr;

  int n_assert = 0;
  int n_fail   = 0;

  bit [31:0] m_rf  [32];
  int        m_cnt [32];

  ysyx_23060187_rf_scoreboard dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rready(rready),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
    .flush(flush), .dbg_gpr(dbg_gpr)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit wr_to(input int a);
    return wen && (waddr == a[4:0]) && (a != 0);
  endfunction

  function automatic bit [31:0] exp_data(input int a);
    return wr_to(a) ? wdata : m_rf[a];
  endfunction

  function automatic bit exp_ready(input int a);
    return (a == 0) || (m_cnt[a] == 0) || (wr_to(a) && m_cnt[a] == 1);
  endfunction

  function automatic bit exp_aready();
    int a = int'(alloc_addr);
    return !(a != 0 && m_cnt[a] == 3 && !wr_to(a));
  endfunction

  task automatic drive(input bit r, input bit we, input int wa, input bit [31:0] wd,
                       input int ra0, input int ra1, input bit ae, input int aa, input bit fl);
    rst = r; wen = we; waddr = wa[4:0]; wdata = wd;
    raddr = {ra1[4:0], ra0[4:0]};
    alloc_en = ae; alloc_addr = aa[4:0]; flush = fl;
  endtask

  task automatic settle();
    int a0, a1;
    #2;
    a0 = int'(raddr[4:0]);
    a1 = int'(raddr[9:5]);
    check("rready", {62'd0, rready}, {62'd0, exp_ready(a1), exp_ready(a0)});
    if (exp_ready(a0)) check("rdata0", {32'd0, rdata[31:0]}, {32'd0, exp_data(a0)});
    if (exp_ready(a1)) check("rdata1", {32'd0, rdata[63:32]}, {32'd0, exp_data(a1)});
    check("alloc_ready", {63'd0, alloc_ready}, {63'd0, exp_aready()});
    check("dbg_gpr", {32'd0, dbg_gpr}, {32'd0, m_rf[10]});
  endtask

  task automatic tick();
    int  aa = int'(alloc_addr);
    int  wa = int'(waddr);
    bit  acc, wr;
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) begin m_rf[r] = 0; m_cnt[r] = 0; end
    end else begin
      acc = alloc_en && exp_aready() && aa != 0 && !flush;
      wr  = wen && wa != 0;
      if (wr) m_rf[wa] = wdata;
      if (flush) begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      end else begin
        if (acc && !(wr && wa == aa)) m_cnt[aa]++;
        if (wr && !(acc && wa == aa) && m_cnt[wa] > 0) m_cnt[wa]--;
      end
    end
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, i, i, 0, 0, 0);
      settle();
      check("reset_rdata", rdata, 64'd0);
      check("reset_rready", {62'd0, rready}, 64'd3);
      tick();
    end

    drive(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0);
    settle(); check("bypass_x5", {32'd0, rdata[31:0]}, 64'hDEADBEEF); tick();
    drive(0, 0, 0, 0, 5, 5, 0, 0, 0);
    settle(); check("stored_x5", rdata, 64'hDEADBEEF_DEADBEEF); tick();

    drive(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); check("x0_zero", rdata, 64'd0); check("x0_ready", {62'd0, rready}, 64'd3); tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      settle(); check("x0_alloc_ready", {63'd0, alloc_ready}, 64'd1); tick();
    end

    for (int k = 0; k < 3; k++) begin drive(0, 0, 0, 0, 7, 7, 1, 7, 0); step(); end
    drive(0, 0, 0, 0, 7, 7, 1, 7, 0);
    settle(); check("full_no_alloc", {63'd0, alloc_ready}, 64'd0); tick();
    drive(0, 1, 7, 1, 7, 0, 0, 0, 0);
    settle(); check("x7_busy_w1", {63'd0, rready[0]}, 64'd0); tick();
    drive(0, 1, 7, 2, 7, 0, 0, 0, 0);
    settle(); check("x7_busy_w2", {63'd0, rready[0]}, 64'd0); tick();
    drive(0, 1, 7, 3, 7, 7, 0, 0, 0);
    settle(); check("x7_last_bypass", {62'd0, rready}, 64'd3);
    check("x7_last_data", {32'd0, rdata[31:0]}, 64'd3); tick();
    drive(0, 0, 0, 0, 7, 7, 0, 0, 0);
    settle(); check("x7_after", rdata, 64'h3_00000003); tick();

    drive(0, 0, 0, 0, 9, 9, 1, 9, 0); step();
    drive(0, 1, 9, 32'h55, 9, 9, 1, 9, 0); step();
    drive(0, 0, 0, 0, 9, 9, 0, 0, 0);
    settle(); check("x9_still_busy", {62'd0, rready}, 64'd0); tick();
    drive(0, 1, 9, 32'h66, 9, 9, 0, 0, 0); step();
    drive(0, 0, 0, 0, 9, 9, 0, 0, 0);
    settle(); check("x9_free", {62'd0, rready}, 64'd3); check("x9_data", rdata, 64'h66_00000066); tick();

    drive(0, 0, 0, 0, 3, 4, 1, 3, 0); step();
    drive(0, 0, 0, 0, 3, 4, 1, 3, 0); step();
    drive(0, 1, 3, 32'hA, 3, 4, 1, 4, 1); step();
    drive(0, 0, 0, 0, 3, 4, 0, 0, 0);
    settle(); check("flush_ready", {62'd0, rready}, 64'd3); check("flush_x3", {32'd0, rdata[31:0]}, 64'hA); tick();

    drive(0, 1, 10, 32'hCAFE, 10, 10, 1, 10, 0); step();
    drive(1, 1, 11, 32'h77, 10, 11, 1, 11, 0); step();
    drive(0, 0, 0, 0, 10, 11, 0, 0, 0);
    settle(); check("rst_mid_data", rdata, 64'd0); check("rst_mid_dbg", {32'd0, dbg_gpr}, 64'd0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 11)),
            $urandom, int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 11)), $urandom_range(0, 39) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
